// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt priority arbiter.
package irq_pkg;

    localparam int unsigned N_REQ_DEF   = 8;
    localparam int unsigned HOLDOFF_DEF = 2;
    localparam int unsigned N_REQ_MAX   = 8;
    localparam int unsigned IDX_MAX_W   = 3;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    // Widest one-hot vector; callers truncate to their own line count.
    function automatic logic [N_REQ_MAX-1:0] onehot(input logic [IDX_MAX_W-1:0] idx);
        onehot = N_REQ_MAX'(1) << idx;
    endfunction

endpackage

// File: rtl/irq_pri_enc.sv
// Combinational highest-index-first encoder over the candidate vector.
module irq_pri_enc #(
    parameter  int unsigned N_REQ = 8,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] cand_i,
    output logic [IDX_W-1:0] winner_c,
    output logic             any_valid_c
);

    // Ascending scan: the last (highest) set bit overwrites earlier hits.
    always_comb begin
        winner_c    = '0;
        any_valid_c = |cand_i;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (cand_i[i]) begin
                winner_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_pri_arbiter.sv
// Edge-capturing interrupt front end with masked priority arbitration and handshake holdoff.
// Optional macro IRQ_SYNC_EN adds a 2-flop synchronizer on req_in.
module irq_pri_arbiter
    import irq_pkg::*;
#(
    parameter  int unsigned N_REQ   = N_REQ_DEF,
    parameter  int unsigned HOLDOFF = HOLDOFF_DEF,
    localparam int unsigned IDX_W   = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] mask,
    input  logic             sw_clr,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready,
    output logic [N_REQ-1:0] pending_o,
    output logic             overflow_o
);

    logic [N_REQ-1:0] req_s;
    logic [N_REQ-1:0] req_q, req_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [N_REQ-1:0] rise, clr_vec, cand;
    logic             overflow_q, overflow_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e           state_q, state_d;
    logic             handshake;
    logic [IDX_W-1:0] winner_c;
    logic             any_valid_c;

`ifdef IRQ_SYNC_EN
    logic [N_REQ-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= req_in;
            sync2_q <= sync1_q;
        end
    end

    assign req_s = sync2_q;
`else
    assign req_s = req_in;
`endif

    assign cand = pending_q & mask;

    irq_pri_enc #(.N_REQ(N_REQ)) u_enc (
        .cand_i      (cand),
        .winner_c    (winner_c),
        .any_valid_c (any_valid_c)
    );

    // Edge capture and pending bookkeeping; a fresh rise beats the handshake clear.
    always_comb begin
        rise       = req_s & ~req_q;
        handshake  = (state_q == ST_PRESENT) && out_valid_q && out_ready && !sw_clr;
        clr_vec    = handshake ? N_REQ'(onehot(IDX_MAX_W'(out_idx_q))) : '0;
        req_d      = req_s;
        pending_d  = sw_clr ? '0 : ((pending_q & ~clr_vec) | rise);
        overflow_d = (|(rise & pending_q & ~clr_vec)) & ~sw_clr;
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                out_valid_d = 1'b0;
                if (any_valid_c && !sw_clr) begin
                    out_idx_d   = winner_c;
                    out_valid_d = 1'b1;
                    state_d     = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (sw_clr) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (HOLDOFF == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = CNT_W'(HOLDOFF - 1);
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q       <= '0;
            pending_q   <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
        end else begin
            req_q       <= req_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_irq_pri_arbiter.sv
// Directed self-checking bench for irq_pri_arbiter (default build, HOLDOFF=2).
module tb_irq_pri_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_in;
    logic [7:0] mask;
    logic       sw_clr;
    logic       out_valid;
    logic [2:0] out_idx;
    logic       out_ready;
    logic [7:0] pending_o;
    logic       overflow_o;

    int errors = 0;
    int checks = 0;

    irq_pri_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_in     (req_in),
        .mask       (mask),
        .sw_clr     (sw_clr),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_ready  (out_ready),
        .pending_o  (pending_o),
        .overflow_o (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        req_in    = 8'hFF;
        mask      = 8'hFF;
        sw_clr    = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_pending", 32'(pending_o), 32'd0);
        check("rst_overflow", 32'(overflow_o), 32'd0);
        tick();
        rst_n = 1'b1;

        // Lines held high through reset count as edges.
        tick();
        check("post_rst_pending", 32'(pending_o), 32'hFF);
        check("post_rst_valid_lo", 32'(out_valid), 32'd0);
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_idx", 32'(out_idx), 32'd7);

        // sw_clr while presenting.
        sw_clr = 1'b1;
        tick();
        check("swclr_valid", 32'(out_valid), 32'd0);
        check("swclr_pending", 32'(pending_o), 32'd0);
        sw_clr = 1'b0;
        req_in = 8'h00;
        tick();
        check("swclr_idle", 32'(out_valid), 32'd0);

        // Priority and drain with holdoff gap.
        req_in = 8'h24;
        tick();
        check("pri_pending", 32'(pending_o), 32'h24);
        req_in    = 8'h00;
        out_ready = 1'b1;
        tick();
        check("pri_valid1", 32'(out_valid), 32'd1);
        check("pri_idx1", 32'(out_idx), 32'd5);
        tick();
        check("pri_gap1", 32'(out_valid), 32'd0);
        check("pri_pending_after1", 32'(pending_o), 32'h04);
        tick();
        check("pri_gap2", 32'(out_valid), 32'd0);
        tick();
        check("pri_gap3", 32'(out_valid), 32'd0);
        tick();
        check("pri_valid2", 32'(out_valid), 32'd1);
        check("pri_idx2", 32'(out_idx), 32'd2);
        tick();
        check("pri_drained", 32'(pending_o), 32'h00);
        check("pri_valid_off", 32'(out_valid), 32'd0);
        tick();
        tick();

        // No preemption of a presented index.
        out_ready = 1'b0;
        req_in    = 8'h02;
        tick();
        req_in = 8'h00;
        tick();
        check("np_idx1", 32'(out_idx), 32'd1);
        check("np_valid1", 32'(out_valid), 32'd1);
        req_in = 8'h40;
        tick();
        check("np_pending", 32'(pending_o), 32'h42);
        check("np_hold_idx", 32'(out_idx), 32'd1);
        req_in = 8'h00;
        tick();
        check("np_hold_idx2", 32'(out_idx), 32'd1);
        check("np_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        check("np_accept_pending", 32'(pending_o), 32'h40);
        tick();
        tick();
        tick();
        check("np_next_valid", 32'(out_valid), 32'd1);
        check("np_next_idx", 32'(out_idx), 32'd6);
        tick();
        tick();
        tick();

        // Masked line stays pending but unpresented.
        mask   = 8'hEF;
        req_in = 8'h10;
        tick();
        req_in = 8'h00;
        check("mask_pending", 32'(pending_o), 32'h10);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("mask_blocked", 32'(out_valid), 32'd0);
        end
        mask = 8'hFF;
        tick();
        check("mask_valid", 32'(out_valid), 32'd1);
        check("mask_idx", 32'(out_idx), 32'd4);
        tick();
        tick();
        tick();

        // Overflow on re-pulse of a pending line.
        out_ready = 1'b0;
        req_in    = 8'h08;
        tick();
        check("ovf_first", 32'(overflow_o), 32'd0);
        req_in = 8'h00;
        tick();
        check("ovf_present_idx", 32'(out_idx), 32'd3);
        req_in = 8'h08;
        tick();
        check("ovf_pulse", 32'(overflow_o), 32'd1);
        req_in = 8'h00;
        tick();
        check("ovf_one_cycle", 32'(overflow_o), 32'd0);

        // Rise on the line cleared by the handshake keeps it pending.
        req_in    = 8'h08;
        out_ready = 1'b1;
        tick();
        check("coll_pending", 32'(pending_o), 32'h08);
        check("coll_overflow", 32'(overflow_o), 32'd0);
        check("coll_valid", 32'(out_valid), 32'd0);
        req_in = 8'h00;
        tick();
        tick();
        tick();
        check("coll_repres_idx", 32'(out_idx), 32'd3);
        check("coll_repres_valid", 32'(out_valid), 32'd1);

        // Async reset dropped in the middle of HOLD.
        req_in = 8'h01;
        tick();
        check("hold_pending", 32'(pending_o), 32'h01);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_idx", 32'(out_idx), 32'd0);
        check("arst_pending", 32'(pending_o), 32'd0);
        check("arst_overflow", 32'(overflow_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
